// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - pipeline hazard controller: stall, branch flush and data-memory wait sequencing
module hazard_controller #(
  parameter int BRANCH_PENALTY = 2,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        clr_cnt_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        pipe_en_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic        mem_timeout_o
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [1:0]  RELOAD  = 2'(BRANCH_PENALTY - 1);
  localparam logic [16:0] TIMEOUT = 17'(MEM_TIMEOUT);

  state_t      state, next_state;
  logic [1:0]  pend, next_pend;
  logic [15:0] wait_cnt;
  logic [16:0] wait_inc;
  logic        mem_busy;
  logic        flush_evt;

  assign mem_busy = mem_req_i & ~mem_ack_i;
  assign wait_inc = {1'b0, wait_cnt} + 17'd1;
  assign state_o  = state;

  // A nonzero pending count means FLUSH rules apply, including the MEM_WAIT ack cycle.
  always_comb begin
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    pipe_en_o     = 1'b0;
    next_state    = state;
    next_pend     = pend;
    flush_evt     = 1'b0;
    if (mem_busy) begin
      next_state = MEM_WAIT;
    end else if (branch_taken_i) begin
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      pipe_en_o     = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      flush_evt     = 1'b1;
      next_pend     = RELOAD;
      next_state    = (RELOAD != 2'd0) ? FLUSH : RUN;
    end else if (pend != 2'd0) begin
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      pipe_en_o     = 1'b1;
      if_id_flush_o = 1'b1;
      next_pend     = pend - 2'd1;
      next_state    = (pend == 2'd1) ? RUN : FLUSH;
    end else if (stall_i) begin
      pipe_en_o     = 1'b1;
      id_ex_flush_o = 1'b1;
      next_state    = RUN;
    end else begin
      pc_en_o    = 1'b1;
      if_id_en_o = 1'b1;
      pipe_en_o  = 1'b1;
      next_state = RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= RUN;
      pend          <= 2'd0;
      wait_cnt      <= 16'd0;
      stall_cnt_o   <= 32'd0;
      flush_cnt_o   <= 32'd0;
      mem_timeout_o <= 1'b0;
    end else begin
      state <= next_state;
      pend  <= next_pend;

      if (clr_cnt_i)
        stall_cnt_o <= 32'd0;
      else if (!pc_en_o && stall_cnt_o != 32'hFFFF_FFFF)
        stall_cnt_o <= stall_cnt_o + 32'd1;

      if (clr_cnt_i)
        flush_cnt_o <= 32'd0;
      else if (flush_evt && flush_cnt_o != 32'hFFFF_FFFF)
        flush_cnt_o <= flush_cnt_o + 32'd1;

      // wait_cnt holds completed MEM_WAIT cycles; wait_inc includes the current one.
      if (state == MEM_WAIT) begin
        if (wait_inc == TIMEOUT)
          mem_timeout_o <= 1'b1;
        if (!mem_busy)
          wait_cnt <= 16'd0;
        else if (wait_cnt != 16'hFFFF)
          wait_cnt <= wait_inc[15:0];
      end else begin
        wait_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed checks of hazard_controller against a behavioural model
module tb_hazard_controller;
  localparam int BP = 3;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch, mem_req, mem_ack, clr_cnt;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en, mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  // Model: remaining squash cycles, waiting flag, MEM_WAIT cycles seen, sticky error, event counts.
  int     m_pend;
  bit     m_wait;
  int     m_wcyc;
  bit     m_to;
  longint m_sc, m_fc;

  always #5 clk = ~clk;

  hazard_controller #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .branch_taken_i(branch),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack), .clr_cnt_i(clr_cnt),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush), .pipe_en_o(pipe_en), .state_o(state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    {stall, branch, mem_req, mem_ack, clr_cnt} = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd1);
    m_pend = 0; m_wait = 0; m_wcyc = 0; m_to = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit s, input bit b, input bit rq, input bit ak, input bit cl);
    bit busy;
    bit e_pc, e_ifen, e_iff, e_idf, e_pipe;
    int e_state;
    @(negedge clk);
    stall = s; branch = b; mem_req = rq; mem_ack = ak; clr_cnt = cl;
    #1;
    busy    = rq && !ak;
    e_state = m_wait ? 1 : (m_pend > 0 ? 2 : 0);
    if (busy)            {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b00000;
    else if (b)          {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b11111;
    else if (m_pend > 0) {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b11101;
    else if (s)          {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b00011;
    else                 {e_pc, e_ifen, e_iff, e_idf, e_pipe} = 5'b11001;
    check("pc_en", 32'(pc_en), 32'(e_pc));
    check("if_id_en", 32'(if_id_en), 32'(e_ifen));
    check("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    check("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    check("pipe_en", 32'(pipe_en), 32'(e_pipe));
    check("state", 32'(state), 32'(e_state));
    check("stall_cnt", stall_cnt, 32'(m_sc));
    check("flush_cnt", flush_cnt, 32'(m_fc));
    check("mem_timeout", 32'(mem_timeout), 32'(m_to));
    // advance the model to the upcoming rising edge
    if (m_wait) begin
      m_wcyc++;
      if (m_wcyc == MT) m_to = 1;
    end
    if (busy) begin
      m_wait = 1;
    end else begin
      m_wait = 0;
      m_wcyc = 0;
      if (b) m_pend = BP - 1;
      else if (m_pend > 0) m_pend--;
    end
    if (cl) m_sc = 0; else if (!e_pc && m_sc < 64'hFFFF_FFFF) m_sc++;
    if (cl) m_fc = 0; else if (!busy && b && m_fc < 64'hFFFF_FFFF) m_fc++;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    {stall, branch, mem_req, mem_ack, clr_cnt} = '0;
    do_reset();

    // single stall cycle in RUN
    step(1, 0, 0, 0, 0);
    after_edge();
    check("stall_once_cnt", stall_cnt, 32'd1);

    // branch beats stall, then BP-1 squash cycles
    do_reset();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < BP - 1; i++) step(1, 0, 0, 0, 0);
    after_edge();
    check("branch_back_to_run", 32'(state), 32'd0);
    check("branch_flush_cnt", flush_cnt, 32'd1);
    check("branch_stall_cnt", stall_cnt, 32'd0);

    // three busy cycles then ack
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    after_edge();
    check("memwait_stall_cnt", stall_cnt, 32'd3);

    // mem wait during FLUSH holds the pending squash count
    do_reset();
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    after_edge();
    check("flush_resume_state", 32'(state), 32'd2);
    step(0, 0, 0, 0, 0);
    after_edge();
    check("flush_done_state", 32'(state), 32'd0);

    // timeout after MT MEM_WAIT cycles, sticky until reset
    do_reset();
    for (int i = 0; i < MT + 1; i++) step(0, 0, 1, 0, 0);
    after_edge();
    check("timeout_set", 32'(mem_timeout), 32'd1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    after_edge();
    check("timeout_sticky", 32'(mem_timeout), 32'd1);
    do_reset();

    // clear wins over a simultaneous increment
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    after_edge();
    check("stall_cnt_five", stall_cnt, 32'd5);
    step(1, 0, 0, 0, 1);
    after_edge();
    check("clr_priority", stall_cnt, 32'd0);

    // random traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 49) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
